// File: rtl/pcie_tl_vc_fifo.sv
// Per-virtual-channel transaction-layer FIFO: NUM_CH independent queues sharing one storage array.
// Latency: a write at edge N is visible on rdata_o and in the status outputs from cycle N+1.
// Backpressure: no stall; a write to a full channel is dropped and flagged, a read of an empty one is ignored and flagged.
module pcie_tl_vc_fifo #(
   parameter int DEPTH_LG2  = 4,
   parameter int DATA_WIDTH = 224,
   parameter int NUM_CH     = 2,
   parameter int AF_THRESH  = (1 << DEPTH_LG2) - 2,
   parameter int AE_THRESH  = 1,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W     = DEPTH_LG2 + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wren_i,
   input  logic [CH_W-1:0]         wch_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic                    rden_i,
   input  logic [CH_W-1:0]         rch_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   input  logic [NUM_CH-1:0]       flush_i,
   input  logic                    err_clr_i,
   output logic [NUM_CH-1:0]       full_o,
   output logic [NUM_CH-1:0]       empty_o,
   output logic [NUM_CH-1:0]       afull_o,
   output logic [NUM_CH-1:0]       aempty_o,
   output logic [NUM_CH*CNT_W-1:0] count_o,
   output logic [NUM_CH-1:0]       ovf_o,
   output logic [NUM_CH-1:0]       udf_o
);

   localparam int DEPTH = 1 << DEPTH_LG2;

   // Shared storage, addressed {channel, pointer low bits}; contents are never reset.
   logic [DATA_WIDTH-1:0] mem [NUM_CH*DEPTH];

   // Per-channel pointers carry one extra MSB so full and empty are distinguishable.
   logic [CNT_W-1:0] wrptr_q [NUM_CH];
   logic [CNT_W-1:0] rdptr_q [NUM_CH];
   logic [CNT_W-1:0] wrptr_d [NUM_CH];
   logic [CNT_W-1:0] rdptr_d [NUM_CH];
   logic [CNT_W-1:0] cnt_d   [NUM_CH];

   logic [NUM_CH-1:0]       full_q, empty_q, afull_q, aempty_q, ovf_q, udf_q;
   logic [NUM_CH-1:0]       full_d, empty_d, afull_d, aempty_d, ovf_d, udf_d;
   logic [NUM_CH-1:0]       wr_hit, rd_hit, wr_acc, rd_acc;
   logic [NUM_CH*CNT_W-1:0] count_q, count_d;
   logic [DEPTH_LG2-1:0]    wr_lo, rd_lo;
   logic                    mem_we;

   // Request decode, acceptance, next-state pointers and next-state status per channel.
   always_comb begin
      wr_hit  = '0;
      rd_hit  = '0;
      wr_acc  = '0;
      rd_acc  = '0;
      full_d  = '0;
      empty_d = '0;
      afull_d = '0;
      aempty_d = '0;
      ovf_d   = '0;
      udf_d   = '0;
      count_d = '0;
      wr_lo   = '0;
      rd_lo   = '0;
      mem_we  = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         // A flushed channel swallows its same-cycle requests without raising errors.
         wr_hit[c] = wren_i && (wch_i == CH_W'(c)) && !flush_i[c];
         rd_hit[c] = rden_i && (rch_i == CH_W'(c)) && !flush_i[c];
         rd_acc[c] = rd_hit[c] && !empty_q[c];
         // A full channel still takes a write when the same cycle pops one of its entries.
         wr_acc[c] = wr_hit[c] && (!full_q[c] || rd_acc[c]);

         wrptr_d[c] = flush_i[c] ? '0 : wrptr_q[c] + CNT_W'(wr_acc[c]);
         rdptr_d[c] = flush_i[c] ? '0 : rdptr_q[c] + CNT_W'(rd_acc[c]);
         cnt_d[c]   = wrptr_d[c] - rdptr_d[c];

         full_d[c]   = (cnt_d[c] == CNT_W'(DEPTH));
         empty_d[c]  = (cnt_d[c] == '0);
         afull_d[c]  = ({{(32-CNT_W){1'b0}}, cnt_d[c]} >= unsigned'(AF_THRESH));
         aempty_d[c] = ({{(32-CNT_W){1'b0}}, cnt_d[c]} <= unsigned'(AE_THRESH));
         count_d[c*CNT_W +: CNT_W] = cnt_d[c];

         // New error events win over a same-cycle clear.
         ovf_d[c] = (wr_hit[c] && !wr_acc[c]) || (ovf_q[c] && !err_clr_i);
         udf_d[c] = (rd_hit[c] && empty_q[c]) || (udf_q[c] && !err_clr_i);

         if (wr_acc[c]) begin
            mem_we = 1'b1;
         end
         if (wch_i == CH_W'(c)) begin
            wr_lo = wrptr_q[c][DEPTH_LG2-1:0];
         end
         if (rch_i == CH_W'(c)) begin
            rd_lo = rdptr_q[c][DEPTH_LG2-1:0];
         end
      end
   end

   // Pointer and registered-status update; reset empties every channel and clears errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wrptr_q[c] <= '0;
            rdptr_q[c] <= '0;
         end
         full_q   <= '0;
         empty_q  <= '1;
         afull_q  <= '0;
         aempty_q <= '1;
         ovf_q    <= '0;
         udf_q    <= '0;
         count_q  <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            wrptr_q[c] <= wrptr_d[c];
            rdptr_q[c] <= rdptr_d[c];
         end
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         count_q  <= count_d;
      end
   end

   // Storage write for an accepted entry; nothing is stored while reset is asserted.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem[{wch_i, wr_lo}] <= wdata_i;
      end
   end

   assign rdata_o  = mem[{rch_i, rd_lo}];
   assign full_o   = full_q;
   assign empty_o  = empty_q;
   assign afull_o  = afull_q;
   assign aempty_o = aempty_q;
   assign count_o  = count_q;
   assign ovf_o    = ovf_q;
   assign udf_o    = udf_q;

endmodule

// File: tb/tb_pcie_tl_vc_fifo.sv
// Bench for pcie_tl_vc_fifo with per-channel queue model of the FIFO rules.
// Inputs change #1 after the rising edge and outputs are sampled there too.
// No backpressure inputs; drops and ignored reads are tracked by the model's sticky flags.
module tb_pcie_tl_vc_fifo;

   localparam int DL    = 4;
   localparam int DEPTH = 16;
   localparam int DW    = 224;
   localparam int NCH   = 2;
   localparam int CW    = 1;
   localparam int CNTW  = 5;
   localparam int AF    = 14;
   localparam int AE    = 1;

   typedef logic [DW-1:0] d_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              wren_i;
   logic [CW-1:0]     wch_i;
   d_t                wdata_i;
   logic              rden_i;
   logic [CW-1:0]     rch_i;
   d_t                rdata_o;
   logic [NCH-1:0]    flush_i;
   logic              err_clr_i;
   logic [NCH-1:0]    full_o, empty_o, afull_o, aempty_o, ovf_o, udf_o;
   logic [NCH*CNTW-1:0] count_o;

   int checks = 0;
   int errors = 0;

   d_t mq [NCH][$];
   bit m_ovf [NCH];
   bit m_udf [NCH];

   always #5 clk = ~clk;

   pcie_tl_vc_fifo #(.DEPTH_LG2(DL), .DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
      .clk(clk), .rst(rst),
      .wren_i(wren_i), .wch_i(wch_i), .wdata_i(wdata_i),
      .rden_i(rden_i), .rch_i(rch_i), .rdata_o(rdata_o),
      .flush_i(flush_i), .err_clr_i(err_clr_i),
      .full_o(full_o), .empty_o(empty_o), .afull_o(afull_o), .aempty_o(aempty_o),
      .count_o(count_o), .ovf_o(ovf_o), .udf_o(udf_o)
   );

   function automatic d_t rnd_data();
      d_t d;
      for (int i = 0; i < 7; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   // Apply one cycle of requests and advance the reference model by the FIFO rules.
   task automatic step(input bit we, input int wc, input d_t wd, input bit re, input int rc,
                       input logic [NCH-1:0] fl, input bit clr, input bit rs);
      bit racc, wacc;
      int rsz, wsz;
      rst = rs; wren_i = we; wch_i = CW'(wc); wdata_i = wd;
      rden_i = re; rch_i = CW'(rc); flush_i = fl; err_clr_i = clr;
      @(posedge clk);
      if (rs) begin
         for (int c = 0; c < NCH; c++) begin
            mq[c].delete(); m_ovf[c] = 0; m_udf[c] = 0;
         end
      end else begin
         rsz  = mq[rc].size();
         wsz  = mq[wc].size();
         racc = re && !fl[rc] && rsz > 0;
         wacc = we && !fl[wc] && (wsz < DEPTH || (racc && rc == wc));
         if (clr) for (int c = 0; c < NCH; c++) begin m_ovf[c] = 0; m_udf[c] = 0; end
         if (re && !fl[rc] && rsz == 0) m_udf[rc] = 1;
         if (we && !fl[wc] && !wacc) m_ovf[wc] = 1;
         if (racc) void'(mq[rc].pop_front());
         if (wacc) mq[wc].push_back(wd);
         for (int c = 0; c < NCH; c++) if (fl[c]) mq[c].delete();
      end
      #1;
   endtask

   task automatic test_reset();
      step(0, 0, '0, 0, 0, '0, 0, 1);
      step(0, 0, '0, 0, 0, '0, 0, 1);
      checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count got %h exp 0", count_o); end
      checks++; if (empty_o !== 2'b11) begin errors++; $display("FAIL reset_empty got %b exp 11", empty_o); end
      checks++; if (aempty_o !== 2'b11) begin errors++; $display("FAIL reset_aempty got %b exp 11", aempty_o); end
      checks++; if (full_o !== 2'b00) begin errors++; $display("FAIL reset_full got %b exp 00", full_o); end
      checks++; if (afull_o !== 2'b00) begin errors++; $display("FAIL reset_afull got %b exp 00", afull_o); end
      checks++; if ({ovf_o, udf_o} !== 4'b0) begin errors++; $display("FAIL reset_err got %b exp 0000", {ovf_o, udf_o}); end
   endtask

   task automatic test_basic();
      d_t a1 = 'hA1;
      d_t a2 = 'hA2;
      step(1, 0, a1, 0, 0, '0, 0, 0);
      checks++; if (empty_o[0] !== 1'b0) begin errors++; $display("FAIL basic_empty0 got %b exp 0", empty_o[0]); end
      checks++; if (rdata_o !== a1) begin errors++; $display("FAIL basic_rdata got %h exp a1", rdata_o); end
      step(1, 0, a2, 0, 0, '0, 0, 0);
      checks++; if (count_o[0 +: CNTW] !== 5'd2) begin errors++; $display("FAIL basic_count0 got %0d exp 2", count_o[0 +: CNTW]); end
      checks++; if (empty_o[1] !== 1'b1 || count_o[CNTW +: CNTW] !== 5'd0) begin errors++; $display("FAIL basic_ch1 got empty %b count %0d exp 1/0", empty_o[1], count_o[CNTW +: CNTW]); end
      step(0, 0, '0, 1, 0, '0, 0, 0);
      checks++; if (rdata_o !== a2) begin errors++; $display("FAIL basic_pop got %h exp a2", rdata_o); end
      step(0, 0, '0, 1, 0, '0, 0, 0);
      checks++; if (empty_o[0] !== 1'b1) begin errors++; $display("FAIL basic_drain got %b exp 1", empty_o[0]); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 1, rnd_data(), 0, 1, '0, 0, 0);
         checks++; if (afull_o[1] !== (i + 1 >= AF)) begin errors++; $display("FAIL fill_afull n=%0d got %b", i + 1, afull_o[1]); end
         checks++; if (full_o[1] !== (i + 1 == DEPTH)) begin errors++; $display("FAIL fill_full n=%0d got %b", i + 1, full_o[1]); end
         checks++; if (aempty_o[1] !== (i + 1 <= AE)) begin errors++; $display("FAIL fill_aempty n=%0d got %b", i + 1, aempty_o[1]); end
      end
      step(1, 1, rnd_data(), 0, 1, '0, 0, 0);
      checks++; if (count_o[CNTW +: CNTW] !== 5'd16) begin errors++; $display("FAIL fill_drop_count got %0d exp 16", count_o[CNTW +: CNTW]); end
      checks++; if (ovf_o !== 2'b10) begin errors++; $display("FAIL fill_ovf got %b exp 10", ovf_o); end
   endtask

   task automatic test_flush();
      step(0, 0, '0, 0, 0, 2'b10, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 1, rnd_data(), 0, 0, '0, 0, 0);
      step(1, 0, 'hB0, 0, 0, '0, 0, 0);
      step(1, 0, 'hB1, 0, 0, '0, 0, 0);
      checks++; if (count_o[CNTW +: CNTW] !== 5'd5) begin errors++; $display("FAIL flush_pre got %0d exp 5", count_o[CNTW +: CNTW]); end
      step(1, 1, rnd_data(), 1, 1, 2'b10, 0, 0);
      checks++; if (count_o[CNTW +: CNTW] !== 5'd0 || empty_o[1] !== 1'b1 || aempty_o[1] !== 1'b1) begin errors++; $display("FAIL flush_ch1 got cnt %0d e %b ae %b exp 0/1/1", count_o[CNTW +: CNTW], empty_o[1], aempty_o[1]); end
      checks++; if (ovf_o !== 2'b10 || udf_o !== 2'b00) begin errors++; $display("FAIL flush_err got ovf %b udf %b exp 10/00", ovf_o, udf_o); end
      step(0, 0, '0, 1, 0, 2'b10, 0, 0);
      checks++; if (count_o[0 +: CNTW] !== 5'd1 || rdata_o !== d_t'('hB1)) begin errors++; $display("FAIL flush_ch0 got cnt %0d data %h exp 1/b1", count_o[0 +: CNTW], rdata_o); end
      step(0, 1, '0, 1, 1, 2'b10, 0, 0);
      checks++; if (udf_o !== 2'b00) begin errors++; $display("FAIL flush_no_udf got %b exp 00", udf_o); end
      step(0, 0, '0, 0, 0, '0, 1, 0);
      checks++; if (ovf_o !== 2'b00) begin errors++; $display("FAIL flush_clr got %b exp 00", ovf_o); end
   endtask

   task automatic test_full_rw();
      d_t v55 = 'h55;
      step(0, 0, '0, 0, 0, 2'b01, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(1, 0, rnd_data(), 0, 0, '0, 0, 0);
      step(1, 0, v55, 1, 0, '0, 0, 0);
      checks++; if (count_o[0 +: CNTW] !== 5'd16 || full_o[0] !== 1'b1) begin errors++; $display("FAIL fullrw_count got %0d full %b exp 16/1", count_o[0 +: CNTW], full_o[0]); end
      checks++; if (ovf_o !== 2'b00) begin errors++; $display("FAIL fullrw_ovf got %b exp 00", ovf_o); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (rdata_o !== mq[0][0]) begin errors++; $display("FAIL fullrw_order i=%0d got %h exp %h", i, rdata_o, mq[0][0]); end
         if (i == DEPTH - 1) begin
            checks++; if (rdata_o !== v55) begin errors++; $display("FAIL fullrw_last got %h exp 55", rdata_o); end
         end
         step(0, 0, '0, 1, 0, '0, 0, 0);
      end
      checks++; if (empty_o[0] !== 1'b1) begin errors++; $display("FAIL fullrw_empty got %b exp 1", empty_o[0]); end
   endtask

   task automatic test_empty_rw();
      step(1, 0, 'h77, 1, 0, '0, 0, 0);
      checks++; if (udf_o !== 2'b01) begin errors++; $display("FAIL emptyrw_udf got %b exp 01", udf_o); end
      checks++; if (count_o[0 +: CNTW] !== 5'd1 || rdata_o !== d_t'('h77)) begin errors++; $display("FAIL emptyrw_store got %0d %h exp 1/77", count_o[0 +: CNTW], rdata_o); end
      step(0, 0, '0, 1, 1, '0, 1, 0);
      checks++; if (udf_o !== 2'b10) begin errors++; $display("FAIL emptyrw_clr_prio got %b exp 10", udf_o); end
      step(0, 0, '0, 0, 0, '0, 1, 0);
      checks++; if (udf_o !== 2'b00) begin errors++; $display("FAIL emptyrw_clr got %b exp 00", udf_o); end
      step(0, 0, '0, 0, 0, 2'b11, 0, 0);
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 800; cyc++) begin
         int wpct = (cyc % 200 < 100) ? 70 : 35;
         bit we = ($urandom_range(0, 99) < wpct);
         bit re = ($urandom_range(0, 99) < 100 - wpct);
         logic [NCH-1:0] fl = ($urandom_range(0, 99) < 2) ? NCH'($urandom_range(1, 3)) : '0;
         bit clr = ($urandom_range(0, 99) < 5);
         int rc = $urandom_range(0, NCH - 1);
         step(we, $urandom_range(0, NCH - 1), rnd_data(), re, rc, fl, clr, cyc == 400);
         if (cyc == 400) begin
            checks++; if (count_o !== '0 || empty_o !== 2'b11 || aempty_o !== 2'b11 || full_o !== '0 || afull_o !== '0 || ovf_o !== '0 || udf_o !== '0) begin errors++; $display("FAIL rnd_midreset got cnt %h e %b ae %b f %b af %b o %b u %b", count_o, empty_o, aempty_o, full_o, afull_o, ovf_o, udf_o); end
         end
         for (int c = 0; c < NCH; c++) begin
            int sz = mq[c].size();
            checks++; if (count_o[c*CNTW +: CNTW] !== CNTW'(sz)) begin errors++; $display("FAIL rnd_count cyc=%0d ch=%0d got %0d exp %0d", cyc, c, count_o[c*CNTW +: CNTW], sz); end
            checks++; if ({full_o[c], empty_o[c], afull_o[c], aempty_o[c]} !== {sz == DEPTH, sz == 0, sz >= AF, sz <= AE}) begin errors++; $display("FAIL rnd_status cyc=%0d ch=%0d got %b exp %b", cyc, c, {full_o[c], empty_o[c], afull_o[c], aempty_o[c]}, {sz == DEPTH, sz == 0, sz >= AF, sz <= AE}); end
            checks++; if ({ovf_o[c], udf_o[c]} !== {m_ovf[c], m_udf[c]}) begin errors++; $display("FAIL rnd_err cyc=%0d ch=%0d got %b exp %b", cyc, c, {ovf_o[c], udf_o[c]}, {m_ovf[c], m_udf[c]}); end
         end
         if (mq[rc].size() > 0) begin
            checks++; if (rdata_o !== mq[rc][0]) begin errors++; $display("FAIL rnd_rdata cyc=%0d ch=%0d got %h exp %h", cyc, rc, rdata_o, mq[rc][0]); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; wren_i = 0; wch_i = '0; wdata_i = '0; rden_i = 0; rch_i = '0;
      flush_i = '0; err_clr_i = 0;
      #1;
      test_reset();
      test_basic();
      test_fill();
      test_flush();
      test_full_rw();
      test_empty_rw();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
